// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program-counter sequencer. It fetches instruction bytes from the
//            program ROM and steps through a four-state FETCH/EXEC/OPERAND/
//            BRANCH sequence. It raises the one-cycle strobe that makes the
//            flags register capture new ALU {c,z} flags. It evaluates
//            conditional jumps against the registered flags.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous, active-high; clears all state
//            stall      - (PCSEQ_STALL_EN only) freeze sequencer while high
//            romData    - ROM byte at address pcOut (combinational)
//            flagsIn    - registered flags {c,z}
//            pcOut      - program counter / ROM address
//            instrOut   - latched current instruction byte
//            fetchPhase - high in FETCH and OPERAND
//            flagsLoad  - one-cycle flag-capture strobe (EXEC of ALU op)
//            jumpTaken  - one-cycle pulse when a branch loads its target
// Config   : define PCSEQ_STALL_EN to add the stall input.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int ADDR_W = 12  // legal 9..12
) (
  input  logic              clk,
  input  logic              reset,
`ifdef PCSEQ_STALL_EN
  input  logic              stall,
`endif
  input  logic [7:0]        romData,
  input  logic [1:0]        flagsIn,
  output logic [ADDR_W-1:0] pcOut,
  output logic [7:0]        instrOut,
  output logic              fetchPhase,
  output logic              flagsLoad,
  output logic              jumpTaken
);

  localparam logic [1:0] c_FETCH   = 2'd0;
  localparam logic [1:0] c_EXEC    = 2'd1;
  localparam logic [1:0] c_OPERAND = 2'd2;
  localparam logic [1:0] c_BRANCH  = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_nextState;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_instr;
  logic [3:0]        r_hi;
  logic [7:0]        r_lo;

  logic              w_stall;
  logic [3:0]        w_opcode;
  logic              w_isAlu;
  logic              w_isBranch;
  logic              w_cond;
  logic [11:0]       w_target;
  logic [ADDR_W-1:0] w_pcInc;

`ifdef PCSEQ_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_opcode   = r_instr[7:4];
  assign w_isAlu    = ~r_instr[7];
  assign w_isBranch = (w_opcode >= 4'h8) && (w_opcode <= 4'hC);
  assign w_target   = {r_hi, r_lo};
  assign w_pcInc    = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Branch condition evaluated on the registered flags during BRANCH.
  always_comb begin
    w_cond = 1'b0;
    case (w_opcode)
      4'h8:    w_cond = flagsIn[1];   // JC
      4'h9:    w_cond = ~flagsIn[1];  // JNC
      4'hA:    w_cond = flagsIn[0];   // JZ
      4'hB:    w_cond = ~flagsIn[0];  // JNZ
      4'hC:    w_cond = 1'b1;         // JMP
      default: w_cond = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_FETCH;
    end else if (!w_stall) begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_FETCH:   w_nextState = c_EXEC;
      c_EXEC:    w_nextState = w_isBranch ? c_OPERAND : c_FETCH;
      c_OPERAND: w_nextState = c_BRANCH;
      c_BRANCH:  w_nextState = c_FETCH;
      default:   w_nextState = c_FETCH;
    endcase
  end

  // Datapath registers: pc, instruction latch and jump-target halves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= '0;
      r_instr <= 8'h00;
      r_hi    <= 4'h0;
      r_lo    <= 8'h00;
    end else if (!w_stall) begin
      case (r_state)
        c_FETCH: r_instr <= romData;
        c_EXEC: begin
          r_pc <= w_pcInc;
          if (w_isBranch) begin
            r_hi <= r_instr[3:0];
          end
        end
        c_OPERAND: r_lo <= romData;
        c_BRANCH: begin
          // Target wider than the pc is truncated, i.e. taken modulo 2^ADDR_W.
          r_pc <= w_cond ? w_target[ADDR_W-1:0] : w_pcInc;
        end
        default: r_pc <= r_pc;
      endcase
    end
  end

  // Output decode. The strobes are decoded from registered state only (plus
  // flags in BRANCH), so they live in different states and never overlap.
  // A stalled EXEC holds its state, so the strobe reappears once when the
  // stall drops.
  always_comb begin
    fetchPhase = (r_state == c_FETCH) || (r_state == c_OPERAND);
    flagsLoad  = (r_state == c_EXEC) && w_isAlu && !w_stall;
    jumpTaken  = (r_state == c_BRANCH) && w_cond && !w_stall;
  end

  assign pcOut    = r_pc;
  assign instrOut = r_instr;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer. An instruction-level
//            reference model (ROM array + model pc) predicts the per-cycle
//            outputs of every instruction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  flagsIn = 2'b00;
  logic [7:0]  romData;
  logic [11:0] pcOut;
  logic [7:0]  instrOut;
  logic        fetchPhase, flagsLoad, jumpTaken;

  logic [7:0]  rom [4096];
  logic [11:0] mPc;
  int          nVec = 0;
  int          nErr = 0;

  always #5 clk = ~clk;
  assign romData = rom[pcOut];

  pc_sequencer #(.ADDR_W(12)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef PCSEQ_STALL_EN
    .stall      (stall),
`endif
    .romData    (romData),
    .flagsIn    (flagsIn),
    .pcOut      (pcOut),
    .instrOut   (instrOut),
    .fetchPhase (fetchPhase),
    .flagsLoad  (flagsLoad),
    .jumpTaken  (jumpTaken)
  );

  // Reset and release on a falling edge; the bench then sits mid-FETCH at pc 0.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mPc   = 12'h000;
  endtask

  // Runs one whole instruction from its FETCH cycle, checking every cycle.
  // Flags are applied during FETCH and held for the rest of the instruction.
  task automatic run_instruction(input logic [1:0] f, input string tag);
    logic [11:0] p;
    logic [7:0]  b, lo;
    logic [3:0]  op;
    bit          isBr, tk;
    int          n;
    logic [11:0] ePc [4];
    bit          eFp [4];
    bit          eFl [4];
    bit          eJt [4];
    p    = mPc;
    b    = rom[p];
    op   = b[7:4];
    lo   = rom[p + 12'd1];
    isBr = (op >= 4'h8) && (op <= 4'hC);
    case (op)
      4'h8:    tk = f[1];
      4'h9:    tk = !f[1];
      4'hA:    tk = f[0];
      4'hB:    tk = !f[0];
      4'hC:    tk = 1'b1;
      default: tk = 1'b0;
    endcase
    n   = isBr ? 4 : 2;
    ePc = '{p, p, p + 12'd1, p + 12'd1};
    eFp = '{1'b1, 1'b0, 1'b1, 1'b0};
    eFl = '{1'b0, (op < 4'h8), 1'b0, 1'b0};
    eJt = '{1'b0, 1'b0, 1'b0, isBr && tk};
    for (int k = 0; k < n; k++) begin
      nVec++;
      if (pcOut !== ePc[k]) begin
        nErr++;
        $display("FAIL %s c%0d pcOut got %h want %h", tag, k, pcOut, ePc[k]);
      end
      nVec++;
      if (fetchPhase !== eFp[k]) begin
        nErr++;
        $display("FAIL %s c%0d fetchPhase got %b want %b", tag, k, fetchPhase, eFp[k]);
      end
      nVec++;
      if (flagsLoad !== eFl[k]) begin
        nErr++;
        $display("FAIL %s c%0d flagsLoad got %b want %b", tag, k, flagsLoad, eFl[k]);
      end
      nVec++;
      if (jumpTaken !== eJt[k]) begin
        nErr++;
        $display("FAIL %s c%0d jumpTaken got %b want %b", tag, k, jumpTaken, eJt[k]);
      end
      if (k >= 1) begin
        nVec++;
        if (instrOut !== b) begin
          nErr++;
          $display("FAIL %s c%0d instrOut got %h want %h", tag, k, instrOut, b);
        end
      end
      if (k == 0) flagsIn = f;
      @(negedge clk);
    end
    mPc = !isBr ? p + 12'd1 : (tk ? {b[3:0], lo} : p + 12'd2);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    nVec++;
    if (pcOut !== 12'h000 || instrOut !== 8'h00 || fetchPhase !== 1'b1 ||
        flagsLoad !== 1'b0 || jumpTaken !== 1'b0) begin
      nErr++;
      $display("FAIL reset_state got pc=%h ir=%h fp=%b fl=%b jt=%b want 000/00/1/0/0",
               pcOut, instrOut, fetchPhase, flagsLoad, jumpTaken);
    end
    rom[12'h000] = 8'hC1; rom[12'h001] = 8'h23;
    rom[12'h123] = 8'h84; rom[12'h124] = 8'h77;
    @(negedge clk);
    reset = 1'b0;
    mPc   = 12'h000;
    run_instruction(2'b00, "rst_jmp");
    @(negedge clk);
    @(negedge clk);  // now mid-OPERAND of the JC at 0x123
    nVec++;
    if (pcOut !== 12'h124 || fetchPhase !== 1'b1) begin
      nErr++;
      $display("FAIL rst_operand got pc=%h fp=%b want 124/1", pcOut, fetchPhase);
    end
    #1 reset = 1'b1;
    #1;
    nVec++;
    if (pcOut !== 12'h000 || instrOut !== 8'h00 || fetchPhase !== 1'b1) begin
      nErr++;
      $display("FAIL rst_async got pc=%h ir=%h fp=%b want 000/00/1", pcOut, instrOut, fetchPhase);
    end
    @(negedge clk);
    reset = 1'b0;
    mPc   = 12'h000;
    run_instruction(2'b00, "rst_first_fetch");
  endtask

  task automatic test_alu();
    rom[12'h000] = 8'h35;
    rom[12'h001] = 8'hD0;
    do_reset();
    run_instruction(2'b11, "alu_35");
    run_instruction(2'b00, "alu_next_nop");
  endtask

  task automatic test_jz();
    rom[12'h000] = 8'hA4; rom[12'h001] = 8'h56;
    rom[12'h002] = 8'hD0; rom[12'h456] = 8'hE0;
    do_reset();
    run_instruction(2'b01, "jz_taken");
    nVec++;
    if (pcOut !== 12'h456) begin
      nErr++;
      $display("FAIL jz_taken_pc got %h want 456", pcOut);
    end
    do_reset();
    run_instruction(2'b00, "jz_not_taken");
    nVec++;
    if (pcOut !== 12'h002) begin
      nErr++;
      $display("FAIL jz_not_taken_pc got %h want 002", pcOut);
    end
  endtask

  task automatic test_conditions();
    for (int op = 8; op <= 12; op++) begin
      for (int f = 0; f < 4; f++) begin
        rom[12'h000] = {op[3:0], 4'($urandom_range(0, 15))};
        rom[12'h001] = 8'($urandom);
        do_reset();
        run_instruction(f[1:0], "cond");
      end
    end
  endtask

  task automatic test_wrap();
    rom[12'h000] = 8'hCF; rom[12'h001] = 8'hFF; rom[12'hFFF] = 8'hD0;
    do_reset();
    run_instruction(2'b00, "wrap_jmp");
    run_instruction(2'b00, "wrap_nop");
    nVec++;
    if (pcOut !== 12'h000) begin
      nErr++;
      $display("FAIL wrap_inc got %h want 000", pcOut);
    end
    rom[12'h001] = 8'hFE; rom[12'hFFE] = 8'h90; rom[12'hFFF] = 8'h55;
    do_reset();
    run_instruction(2'b00, "wrap_jmp2");
    run_instruction(2'b10, "wrap_jnc");
    nVec++;
    if (pcOut !== 12'h000) begin
      nErr++;
      $display("FAIL wrap_jnc got %h want 000", pcOut);
    end
  endtask

  task automatic test_jump_self();
    rom[12'h000] = 8'hC0; rom[12'h001] = 8'h00;
    do_reset();
    for (int i = 0; i < 3; i++) run_instruction(2'($urandom), "jmp_self");
  endtask

  task automatic test_random();
    for (int a = 0; a < 4096; a++) rom[a] = 8'($urandom);
    do_reset();
    for (int i = 0; i < 400; i++) run_instruction(2'($urandom), "random");
  endtask

`ifdef PCSEQ_STALL_EN
  task automatic test_stall();
    int pulses;
    pulses = 0;
    rom[12'h000] = 8'h12;
    do_reset();
    @(negedge clk);  // mid-EXEC
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      nVec++;
      if (pcOut !== 12'h000 || fetchPhase !== 1'b0 || instrOut !== 8'h12 || flagsLoad !== 1'b0) begin
        nErr++;
        $display("FAIL stall_hold got pc=%h fp=%b ir=%h fl=%b want 000/0/12/0",
                 pcOut, fetchPhase, instrOut, flagsLoad);
      end
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    if (flagsLoad === 1'b1) pulses++;
    @(negedge clk);
    if (flagsLoad === 1'b1) pulses++;
    nVec++;
    if (pulses != 1 || pcOut !== 12'h001) begin
      nErr++;
      $display("FAIL stall_release got pulses=%0d pc=%h want 1/001", pulses, pcOut);
    end
  endtask
`endif

  initial begin
    for (int a = 0; a < 4096; a++) rom[a] = 8'hD0;
    test_reset();
    test_alu();
    test_jz();
    test_conditions();
    test_wrap();
    test_jump_self();
`ifdef PCSEQ_STALL_EN
    test_stall();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
`default_nettype wire
